// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions.
//   REG_ADDR_W / NUM_REGS : architectural register file geometry
//   reg_idx_t             : register index type
//   onehot_reg()          : 32-bit decode of a register index; bit 0 is
//                           always 0 because x0 never holds a value.
package rv32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    function automatic logic [NUM_REGS-1:0] onehot_reg(input reg_idx_t idx);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[idx] = 1'b1;
        v[0] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Load scoreboard for the 3-stage RV32I pipeline.
// Tracks destination registers of loads issued from EX whose data has not
// yet come back from the variable-latency data-memory port, and stalls ID
// when its instruction reads or overwrites one of them, or when it reads the
// destination of a load issuing from EX in the same cycle.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rs1_id, rs2_id, uses_rs*_id    ID source operands and their use flags
//   rd_id, reg_write_id            ID destination
//   is_load_id                     ID instruction is a load
//   issue_ex, rd_ex, reg_write_ex,
//   is_load_ex                     EX instruction issuing this cycle
//   rsp_valid, rsp_rd              returning load data and its destination
//   stall_id                       hold PC/IF-ID, bubble into EX
//   pending_mask                   registered pending bitmap (bit 0 always 0)
//   outstanding                    loads in flight
//   full                           outstanding == MAX_OUTSTANDING
//   rsp_err                        sticky protocol error flag
//   stall_cycles                   stall counter
//
// Build option: define LOAD_SCOREBOARD_STATS_EN to count stall cycles in
// stall_cycles (saturating); otherwise stall_cycles is tied to 0.
module load_scoreboard
    import rv32_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  reg_idx_t            rs1_id,
    input  reg_idx_t            rs2_id,
    input  logic                uses_rs1_id,
    input  logic                uses_rs2_id,
    input  reg_idx_t            rd_id,
    input  logic                reg_write_id,
    input  logic                is_load_id,
    input  logic                issue_ex,
    input  reg_idx_t            rd_ex,
    input  logic                reg_write_ex,
    input  logic                is_load_ex,
    input  logic                rsp_valid,
    input  reg_idx_t            rsp_rd,
    output logic                stall_id,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [CNT_W-1:0]    outstanding,
    output logic                full,
    output logic                rsp_err,
    output logic [31:0]         stall_cycles
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] mask_q;
    logic [NUM_REGS-1:0] eff_mask;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic                issue_ld;
    logic                rsp_bad;
    logic                rsp_ok;
    logic                ovf;
    logic                inc;
    logic                ex_use;

    assign issue_ld = issue_ex & is_load_ex;

    // A response is only trusted when something is in flight and, for a real
    // register, its pending bit is set; anything else is flagged and ignored.
    assign rsp_bad = rsp_valid &
                     ((cnt_q == '0) | ((rsp_rd != '0) & ~mask_q[rsp_rd]));
    assign rsp_ok  = rsp_valid & ~rsp_bad;

    assign full = (cnt_q == MAX_CNT);
    // Issuing into a full scoreboard without a freeing response: saturate.
    assign ovf  = issue_ld & full & ~rsp_ok;
    assign inc  = issue_ld & ~ovf;

    assign set_vec = (issue_ld & reg_write_ex) ? onehot_reg(rd_ex) : '0;
    assign clr_vec = rsp_ok ? onehot_reg(rsp_rd) : '0;

    // Register file is write-first: a register returning this cycle is
    // already readable by ID.
    assign eff_mask = mask_q & ~(rsp_valid ? onehot_reg(rsp_rd) : '0);

    // Same-cycle load-use on the load currently in EX; forwarding cannot
    // supply load data this early.
    assign ex_use = issue_ld & reg_write_ex & (rd_ex != '0) &
                    ((uses_rs1_id & (rs1_id == rd_ex)) |
                     (uses_rs2_id & (rs2_id == rd_ex)));

    // eff_mask bit 0 is always 0, so x0 never stalls.
    assign stall_id = (uses_rs1_id  & eff_mask[rs1_id]) |
                      (uses_rs2_id  & eff_mask[rs2_id]) |
                      (reg_write_id & eff_mask[rd_id])  |
                      (is_load_id & full & ~rsp_valid)  |
                      ex_use;

    // Bitmap / counter / error state. Set wins over clear for the same
    // register so a back-to-back reload stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            mask_q <= (mask_q & ~clr_vec) | set_vec;
            case ({inc, rsp_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (rsp_bad | ovf) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pending_mask = mask_q;
    assign outstanding  = cnt_q;
    assign rsp_err      = err_q;

`ifdef LOAD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_id && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_load_scoreboard.sv
module tb_load_scoreboard;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    reg_idx_t    rs1_id, rs2_id, rd_id, rd_ex, rsp_rd;
    logic        uses_rs1_id, uses_rs2_id, reg_write_id, is_load_id;
    logic        issue_ex, reg_write_ex, is_load_ex, rsp_valid;
    logic        stall_id, full, rsp_err;
    logic [31:0] pending_mask;
    logic [1:0]  outstanding;
    logic [31:0] stall_cycles;

    load_scoreboard #(.MAX_OUTSTANDING(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .uses_rs1_id  (uses_rs1_id),
        .uses_rs2_id  (uses_rs2_id),
        .rd_id        (rd_id),
        .reg_write_id (reg_write_id),
        .is_load_id   (is_load_id),
        .issue_ex     (issue_ex),
        .rd_ex        (rd_ex),
        .reg_write_ex (reg_write_ex),
        .is_load_ex   (is_load_ex),
        .rsp_valid    (rsp_valid),
        .rsp_rd       (rsp_rd),
        .stall_id     (stall_id),
        .pending_mask (pending_mask),
        .outstanding  (outstanding),
        .full         (full),
        .rsp_err      (rsp_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] mask;
        int          outst;
        logic        full;
        logic        err;
        logic [31:0] stats;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   stall_acc = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] got,
                       input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s.%s got=0x%0h expected=0x%0h", nm, fld, got, req);
        end
    endtask

    // Monitor: every expectation belongs to the cycle it was issued in and
    // is checked mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "stall_id",     {31'd0, stall_id},     {31'd0, e.stall});
                chk(e.name, "pending_mask", pending_mask,          e.mask);
                chk(e.name, "outstanding",  {30'd0, outstanding},  32'(e.outst));
                chk(e.name, "full",         {31'd0, full},         {31'd0, e.full});
                chk(e.name, "rsp_err",      {31'd0, rsp_err},      {31'd0, e.err});
                chk(e.name, "stall_cycles", stall_cycles,          e.stats);
            end
        end
    end

    task automatic idle_in();
        rs1_id = '0; rs2_id = '0; rd_id = '0; rd_ex = '0; rsp_rd = '0;
        uses_rs1_id = 0; uses_rs2_id = 0; reg_write_id = 0; is_load_id = 0;
        issue_ex = 0; reg_write_ex = 0; is_load_ex = 0; rsp_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic expect_now(input string nm, input logic s, input logic [31:0] m,
                              input int o, input logic f, input logic e);
        exp_t x;
        x.name = nm; x.stall = s; x.mask = m; x.outst = o; x.full = f; x.err = e;
`ifdef LOAD_SCOREBOARD_STATS_EN
        x.stats = 32'(stall_acc);
`else
        x.stats = 32'd0;
`endif
        exp_q.push_back(x);
        if (s) stall_acc++;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall_acc = 0;
    endtask

    task automatic ex_load(input reg_idx_t rd, input logic wr);
        issue_ex = 1; is_load_ex = 1; reg_write_ex = wr; rd_ex = rd;
    endtask

    task automatic rsp(input reg_idx_t rd);
        rsp_valid = 1; rsp_rd = rd;
    endtask

    // ID: add x6, x5, x1
    task automatic id_add_x6_x5_x1();
        uses_rs1_id = 1; rs1_id = 5'd5; uses_rs2_id = 1; rs2_id = 5'd1;
        reg_write_id = 1; rd_id = 5'd6;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        do_reset();
        expect_now("reset", 0, 32'h0, 0, 0, 0);

        // Load x5, response three cycles later, dependent add in ID
        tick(); ex_load(5, 1); id_add_x6_x5_x1();
        expect_now("x5_exuse", 1, 32'h0, 0, 0, 0);
        tick(); id_add_x6_x5_x1();
        expect_now("x5_pend1", 1, 32'h20, 1, 0, 0);
        tick(); id_add_x6_x5_x1();
        expect_now("x5_pend2", 1, 32'h20, 1, 0, 0);
        tick(); id_add_x6_x5_x1(); rsp(5);
        expect_now("x5_bypass", 0, 32'h20, 1, 0, 0);
        tick();
        expect_now("x5_clear", 0, 32'h0, 0, 0, 0);

        // EX load x7 vs EX add x7 with an ID reader
        tick(); ex_load(7, 1); uses_rs2_id = 1; rs2_id = 5'd7;
        expect_now("x7_ld_use", 1, 32'h0, 0, 0, 0);
        tick(); rsp(7);
        expect_now("x7_rsp", 0, 32'h80, 1, 0, 0);
        tick(); issue_ex = 1; reg_write_ex = 1; rd_ex = 5'd7;
        uses_rs1_id = 1; rs1_id = 5'd7;
        expect_now("x7_alu_fwd", 0, 32'h0, 0, 0, 0);

        // Fill to MAX_OUTSTANDING, then a load in ID
        tick(); ex_load(10, 1);
        expect_now("fill_a", 0, 32'h0, 0, 0, 0);
        tick(); ex_load(11, 1);
        expect_now("fill_b", 0, 32'h400, 1, 0, 0);
        tick(); is_load_id = 1; reg_write_id = 1; rd_id = 5'd12;
        uses_rs1_id = 1; rs1_id = 5'd2;
        expect_now("full_stall", 1, 32'hC00, 2, 1, 0);
        tick(); is_load_id = 1; reg_write_id = 1; rd_id = 5'd12;
        uses_rs1_id = 1; rs1_id = 5'd2; rsp(10);
        expect_now("full_rsp", 0, 32'hC00, 2, 1, 0);
        tick(); ex_load(12, 1);
        expect_now("refill", 0, 32'h800, 1, 0, 0);
        tick();
        expect_now("refull", 0, 32'h1800, 2, 1, 0);
        tick(); rsp(11);
        expect_now("drain_a", 0, 32'h1800, 2, 1, 0);
        tick(); rsp(12);
        expect_now("drain_b", 0, 32'h1000, 1, 0, 0);
        tick();
        expect_now("drained", 0, 32'h0, 0, 0, 0);

        // Same-cycle issue and response on x9
        tick(); ex_load(9, 1);
        expect_now("x9_first", 0, 32'h0, 0, 0, 0);
        tick(); ex_load(9, 1); rsp(9);
        expect_now("x9_both", 0, 32'h200, 1, 0, 0);
        tick();
        expect_now("x9_held", 0, 32'h200, 1, 0, 0);
        tick(); rsp(9);
        expect_now("x9_rsp", 0, 32'h200, 1, 0, 0);
        tick();
        expect_now("x9_clear", 0, 32'h0, 0, 0, 0);

        // Response with nothing outstanding; load to x0
        tick(); rsp(3);
        expect_now("orphan_rsp", 0, 32'h0, 0, 0, 0);
        tick();
        expect_now("err_sticky", 0, 32'h0, 0, 0, 1);
        tick(); ex_load(0, 1); uses_rs1_id = 1; rs1_id = 5'd0;
        expect_now("x0_ex", 0, 32'h0, 0, 0, 1);
        tick(); uses_rs1_id = 1; rs1_id = 5'd0; reg_write_id = 1; rd_id = 5'd0;
        expect_now("x0_id", 0, 32'h0, 1, 0, 1);
        tick(); rsp(0);
        expect_now("x0_rsp", 0, 32'h0, 1, 0, 1);
        tick();
        expect_now("x0_done", 0, 32'h0, 0, 0, 1);

        // Response for a register whose bit is clear
        do_reset();
        expect_now("reset2", 0, 32'h0, 0, 0, 0);
        tick(); ex_load(4, 1);
        expect_now("x4_issue", 0, 32'h0, 0, 0, 0);
        tick(); rsp(8);
        expect_now("x8_bad", 0, 32'h10, 1, 0, 0);
        tick();
        expect_now("x8_held", 0, 32'h10, 1, 0, 1);
        tick(); rsp(4);
        expect_now("x4_rsp", 0, 32'h10, 1, 0, 1);
        tick();
        expect_now("x4_done", 0, 32'h0, 0, 0, 1);

        // Four-cycle stall, then reset with a load in flight
        do_reset();
        expect_now("reset3", 0, 32'h0, 0, 0, 0);
        tick(); ex_load(13, 1);
        expect_now("x13_issue", 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); uses_rs2_id = 1; rs2_id = 5'd13;
            expect_now("x13_stall", 1, 32'h2000, 1, 0, 0);
        end
        tick();
        expect_now("x13_count", 0, 32'h2000, 1, 0, 0);
        do_reset();
        expect_now("rst_flight", 0, 32'h0, 0, 0, 0);

        // Issue while full without a response saturates and flags an error
        tick(); ex_load(1, 1);
        expect_now("sat_a", 0, 32'h0, 0, 0, 0);
        tick(); ex_load(2, 1);
        expect_now("sat_b", 0, 32'h2, 1, 0, 0);
        tick(); ex_load(3, 0);
        expect_now("sat_c", 0, 32'h6, 2, 1, 0);
        tick();
        expect_now("sat_hold", 0, 32'h6, 2, 1, 1);

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_scoreboard.md
Name: load_scoreboard

Overview:
- Stall-side counterpart to the EX->ID forwarding path in the 3-stage RV32I pipeline.
- Tracks destination registers of issued loads whose data has not yet returned from the variable-latency data-memory port.
- Raises `stall_id` when the Decode instruction reads or overwrites a pending register, or hits the immediate EX-stage load-use case that forwarding cannot cover.
- Sits beside the hazard logic between ID and EX; consumes EX issue info and memory load responses.

Parameters:
- MAX_OUTSTANDING, 2, maximum loads in flight; range 1-15.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- rs1_id  input  5  ID source 1 index
- rs2_id  input  5  ID source 2 index
- uses_rs1_id  input  1  ID instruction reads rs1
- uses_rs2_id  input  1  ID instruction reads rs2
- rd_id  input  5  ID destination index
- reg_write_id  input  1  ID instruction writes rd_id
- is_load_id  input  1  ID instruction is a load
- issue_ex  input  1  EX instruction valid and issuing this cycle
- rd_ex  input  5  EX destination index
- reg_write_ex  input  1  EX writes rd_ex
- is_load_ex  input  1  EX instruction is a load
- rsp_valid  input  1  load data returning this cycle
- rsp_rd  input  5  destination of returning load
- stall_id  output  1  hold PC/IF-ID, bubble into EX
- pending_mask  output  32  registered pending bitmap; bit 0 always 0
- outstanding  output  CNT_W  loads in flight
- full  output  1  outstanding == MAX_OUTSTANDING
- rsp_err  output  1  sticky: unexpected response seen
- stall_cycles  output  32  stall counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous, active-high. All state updates on the `clk` rising edge.
- Reset values: `pending_mask`=0, `outstanding`=0, `rsp_err`=0, `stall_cycles`=0. `stall_id` and `full` are combinational and read 0 after reset with inputs idle.
- Issue event: `issue_ex & is_load_ex`.
  - `outstanding` increments.
  - If `reg_write_ex & rd_ex!=0`, `pending_mask[rd_ex]` is set on the next edge.
- Response event: `rsp_valid`.
  - `outstanding` decrements.
  - `pending_mask[rsp_rd]` is cleared.
- Simultaneous issue and response:
  - Counter is unchanged.
  - Same register in both: set wins, so the bit stays 1 for the new load.
- Unexpected response: `rsp_valid` while `outstanding==0`, or `rsp_rd!=0` with its bit clear.
  - `rsp_err` is set.
  - Counter is held (never underflows).
  - Bitmap is unchanged.
  - `rsp_err` clears only on `rst`.
- Response bypass: the register file is write-first, so `stall_id` uses the effective mask `pending_mask & ~(rsp_valid ? onehot(rsp_rd) : 0)`. ID un-stalls in the same cycle the response arrives.
- `stall_id` is combinational, the OR of:
  - `uses_rs1_id & eff[rs1_id]`
  - `uses_rs2_id & eff[rs2_id]`
  - `reg_write_id & eff[rd_id]` (WAW on a pending load)
  - `is_load_id & full & ~rsp_valid`
  - `issue_ex & is_load_ex & reg_write_ex & rd_ex!=0 & ((uses_rs1_id & rs1_id==rd_ex) | (uses_rs2_id & rs2_id==rd_ex))` (EX load-use)
  - Index 0 never causes a stall.
- Issue while full: `issue_ex & is_load_ex` while `full` with no response is a protocol violation. `outstanding` saturates at MAX_OUTSTANDING and `rsp_err` is set.
- Flush: a branch redirect does not clear the scoreboard; issued loads always return.
- Reset mid-flight: `rst` discards all pending state. Memory must also be reset.

Optional Feature:
- Macro: LOAD_SCOREBOARD_STATS_EN.
- Defined:
  - `stall_cycles` increments on every cycle with `stall_id=1`.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by `rst`.
- Undefined: `stall_cycles` is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package `rv32_pkg`:
  - REG_ADDR_W=5, NUM_REGS=32.
  - `reg_idx_t` typedef.
  - `onehot_reg` function returning a 32-bit decode with bit 0 forced 0.
- No sub-module required. The bitmap, counter and stall compare stay in one module.

Test Plan:
- Load x5 issued, response 3 cycles later; ID `add x6,x5,x1` → `stall_id`=1 for 3 cycles, 0 in the response cycle; `pending_mask`=0x20 then 0.
- EX load x7 and ID reads x7 in the same cycle → `stall_id`=1; with EX `add x7` instead → `stall_id`=0.
- MAX_OUTSTANDING=2: two loads issued, ID load → `full`=1, `stall_id`=1; `rsp_valid` same cycle → `stall_id`=0, `outstanding` stays 2 after issue.
- Same-cycle issue of load x9 and response for x9 → `pending_mask[9]`=1, `outstanding` unchanged.
- `rsp_valid` with `outstanding`=0 → `rsp_err`=1 sticky, `outstanding`=0; load to x0 → no bitmap bit, x0 reader never stalls.
- Four-cycle stall with LOAD_SCOREBOARD_STATS_EN → `stall_cycles`=4; `rst` mid-flight → all outputs 0 the next cycle.
